// File: rtl/store_lane_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : store_lane_ctrl                                               |
// | Purpose  : Memory-stage store path. Turns a right-justified store        |
// |            request into lane-aligned bus write beats. Stores that cross  |
// |            a bus-word boundary are split into two beats, or rejected     |
// |            with an error pulse when splitting is disabled.               |
// | Ports    : clk, rst        - clock / async active-high reset            |
// |            req_valid/ready - request handshake (ready only in IDLE)      |
// |            req_addr/op/wdata - byte address, size code, store data      |
// |            bus_valid/ready - bus write beat handshake                    |
// |            bus_addr/wdata/be - aligned address, lane data, byte enables |
// |            done / err      - one-cycle completion / rejection pulses     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module store_lane_ctrl #(
  parameter int DW               = 32,
  parameter int AW               = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [1:0]      req_op,
  input  logic [DW-1:0]   req_wdata,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_be,
  output logic            done,
  output logic            err
);

  localparam int BEW = DW / 8;
  localparam int OW  = $clog2(BEW);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [OW-1:0]   off_q, off_d;
  logic [DW-1:0]   data_q, data_d;
  logic [BEW-1:0]  ones_q, ones_d;   // right-justified n-byte mask
  logic            last_q, last_d;   // single-beat store

  // Accept-time decode of the incoming request
  logic [3:0]      req_n;
  logic [OW-1:0]   req_off;
  logic [BEW-1:0]  req_ones;
  logic [DW-1:0]   req_data_m;
  logic            req_fits;
  logic            req_illegal;

  assign req_n       = 4'd1 << req_op;
  assign req_off     = req_addr[OW-1:0];
  assign req_fits    = (32'(req_off) + 32'(req_n)) <= 32'(BEW);
  assign req_illegal = (DW == 32) && (req_op == 2'b11);

  // Bytes above the store size are dropped so disabled lanes drive zero.
  always_comb begin
    req_ones   = '0;
    req_data_m = '0;
    for (int i = 0; i < BEW; i++) begin
      req_ones[i]          = (i < int'(req_n));
      req_data_m[8*i +: 8] = req_ones[i] ? req_wdata[8*i +: 8] : 8'h00;
    end
  end

  // Shifting into a double-width vector yields both beats at once:
  // the low half is the first bus word, the high half spills into the next.
  logic [2*BEW-1:0] be_wide;
  logic [2*DW-1:0]  data_wide;

  assign be_wide   = {{BEW{1'b0}}, ones_q} << off_q;
  assign data_wide = {{DW{1'b0}}, data_q} << {off_q, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      data_q  <= '0;
      ones_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      data_q  <= data_d;
      ones_q  <= ones_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    data_d  = data_q;
    ones_d  = ones_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = {req_addr[AW-1:OW], {OW{1'b0}}};
          off_d  = req_off;
          data_d = req_data_m;
          ones_d = req_ones;
          last_d = req_fits;
          if (req_illegal)           state_d = ERR;
          else if (req_fits)         state_d = BEAT0;
          else if (SPLIT_MISALIGNED) state_d = BEAT0;
          else                       state_d = ERR;
        end
      end
      // bus_valid is constant 1 in the beat states, so bus_ready alone
      // completes the handshake.
      BEAT0:   if (bus_ready) state_d = last_q ? DONE : BEAT1;
      BEAT1:   if (bus_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so reset clears them at once.
  always_comb begin
    req_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    err       = (state_q == ERR);
    bus_valid = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    case (state_q)
      BEAT0: begin
        bus_valid = 1'b1;
        bus_addr  = base_q;
        bus_be    = be_wide[BEW-1:0];
        bus_wdata = data_wide[DW-1:0];
      end
      BEAT1: begin
        bus_valid = 1'b1;
        bus_addr  = base_q + AW'(BEW);
        bus_be    = be_wide[2*BEW-1:BEW];
        bus_wdata = data_wide[2*DW-1:DW];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_lane_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_store_lane_ctrl                                            |
// | Purpose  : Self-checking bench for store_lane_ctrl (DW=32 split, DW=32   |
// |            reject, DW=64 split instances).                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_store_lane_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DW=32, splitting enabled
  logic        req_valid, req_ready, bus_valid, bus_ready, done, err;
  logic [31:0] req_addr, req_wdata, bus_addr, bus_wdata;
  logic [1:0]  req_op;
  logic [3:0]  bus_be;

  store_lane_ctrl #(.DW(32), .AW(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_wdata(req_wdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .done(done), .err(err)
  );

  // DW=32, splitting disabled
  logic        n_req_valid, n_req_ready, n_bus_valid, n_bus_ready, n_done, n_err;
  logic [31:0] n_req_addr, n_req_wdata, n_bus_addr, n_bus_wdata;
  logic [1:0]  n_req_op;
  logic [3:0]  n_bus_be;

  store_lane_ctrl #(.DW(32), .AW(32), .SPLIT_MISALIGNED(1'b0)) u_nos (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_addr(n_req_addr),
    .req_op(n_req_op), .req_wdata(n_req_wdata),
    .bus_valid(n_bus_valid), .bus_ready(n_bus_ready), .bus_addr(n_bus_addr),
    .bus_wdata(n_bus_wdata), .bus_be(n_bus_be), .done(n_done), .err(n_err)
  );

  // DW=64, splitting enabled
  logic        w_req_valid, w_req_ready, w_bus_valid, w_bus_ready, w_done, w_err;
  logic [31:0] w_req_addr, w_bus_addr;
  logic [63:0] w_req_wdata, w_bus_wdata;
  logic [1:0]  w_req_op;
  logic [7:0]  w_bus_be;

  store_lane_ctrl #(.DW(64), .AW(32), .SPLIT_MISALIGNED(1'b1)) u_d64 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
    .req_op(w_req_op), .req_wdata(w_req_wdata),
    .bus_valid(w_bus_valid), .bus_ready(w_bus_ready), .bus_addr(w_bus_addr),
    .bus_wdata(w_bus_wdata), .bus_be(w_bus_be), .done(w_done), .err(w_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Expected beats for the DW=32 instance
  logic [31:0] exp_addr[4];
  logic [3:0]  exp_be[4];
  logic [31:0] exp_wd[4];

  // Observed behaviour of one store on the DW=32 instance
  int          obs_n, obs_err_cyc, obs_done_cyc, obs_first_valid, obs_last_hs;
  bit          obs_both, obs_timeout;
  logic [31:0] obs_addr[4];
  logic [3:0]  obs_be[4];
  logic [31:0] obs_wd[4];

  // Reference: walk the store byte by byte; each byte lands in the bus word
  // holding its own address, and a new beat starts whenever that word changes.
  task automatic model(input logic [31:0] a, input logic [1:0] op, input logic [31:0] d,
                       output int en, output bit eerr);
    int          n;
    int          lane;
    logic [31:0] ba;
    logic [31:0] wa;
    en   = 0;
    eerr = 1'b0;
    n    = 1 << op;
    if (op == 2'd3) begin
      eerr = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      ba   = a + 32'(k);
      wa   = {ba[31:2], 2'b00};
      lane = int'(ba[1:0]);
      if (en == 0 || exp_addr[en-1] != wa) begin
        exp_addr[en] = wa;
        exp_be[en]   = '0;
        exp_wd[en]   = '0;
        en++;
      end
      exp_be[en-1][lane]        = 1'b1;
      exp_wd[en-1][8*lane +: 8] = d[8*k +: 8];
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after
  // done/err was observed.
  task automatic run_store(input logic [31:0] a, input logic [1:0] op,
                           input logic [31:0] d, input int stall_pct);
    int          cyc;
    bit          fin, prev_stall, rdy;
    logic [31:0] pa, pw;
    logic [3:0]  pb;
    obs_n = 0; obs_err_cyc = -1; obs_done_cyc = -1; obs_first_valid = -1;
    obs_last_hs = -1; obs_both = 1'b0; obs_timeout = 1'b0;
    pa = '0; pw = '0; pb = '0;
    chk("req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_op = op; req_wdata = d; bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_op = 2'($urandom);
    cyc = 1; fin = 1'b0; prev_stall = 1'b0;
    while (!fin) begin
      if (done && err) obs_both = 1'b1;
      if (done) begin obs_done_cyc = cyc; fin = 1'b1; end
      if (err)  begin obs_err_cyc  = cyc; fin = 1'b1; end
      if (bus_valid) begin
        if (obs_first_valid < 0) obs_first_valid = cyc;
        if (prev_stall) begin
          chk("stall_addr", 64'(bus_addr), 64'(pa));
          chk("stall_be", 64'(bus_be), 64'(pb));
          chk("stall_wdata", 64'(bus_wdata), 64'(pw));
        end
        rdy = ($urandom_range(99) >= stall_pct);
        bus_ready = rdy;
        if (rdy) begin
          if (obs_n < 4) begin
            obs_addr[obs_n] = bus_addr; obs_be[obs_n] = bus_be; obs_wd[obs_n] = bus_wdata;
          end
          obs_n++;
          obs_last_hs = cyc;
          prev_stall  = 1'b0;
        end else begin
          prev_stall = 1'b1;
          pa = bus_addr; pb = bus_be; pw = bus_wdata;
        end
      end else begin
        bus_ready  = 1'($urandom);
        prev_stall = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if (!fin && cyc > 40) begin obs_timeout = 1'b1; fin = 1'b1; end
    end
    bus_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int en, input bit eerr, input int stall_pct);
    chk({tag, "_timeout"}, 64'(obs_timeout), 64'd0);
    chk({tag, "_done_err_overlap"}, 64'(obs_both), 64'd0);
    if (eerr) begin
      chk({tag, "_err_cycle"}, 64'(obs_err_cyc), 64'd1);
      chk({tag, "_err_no_valid"}, 64'(obs_n), 64'd0);
      chk({tag, "_err_no_done"}, 64'(obs_done_cyc), 64'(-1));
    end else begin
      chk({tag, "_first_valid"}, 64'(obs_first_valid), 64'd1);
      chk({tag, "_beats"}, 64'(obs_n), 64'(en));
      for (int i = 0; i < en && i < 4; i++) begin
        chk({tag, "_addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
        chk({tag, "_be"}, 64'(obs_be[i]), 64'(exp_be[i]));
        chk({tag, "_wdata"}, 64'(obs_wd[i]), 64'(exp_wd[i]));
      end
      chk({tag, "_done_after_last_beat"}, 64'(obs_done_cyc), 64'(obs_last_hs + 1));
      if (stall_pct == 0) chk({tag, "_done_cycle"}, 64'(obs_done_cyc), 64'(en + 1));
      chk({tag, "_no_err"}, 64'(obs_err_cyc), 64'(-1));
    end
    chk({tag, "_req_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic [31:0] data;
    int          n;
    bit          e;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          en;
    bit          eerr;
    logic [31:0] a, d;
    logic [1:0]  op;

    vecs[0] = '{32'h0000_1003, 2'd0, 32'h0000_00AB, 1, 1'b0, 32'h1000, 4'b1000, 32'hAB00_0000, 32'h0, 4'h0, 32'h0};
    vecs[1] = '{32'h0000_2002, 2'd1, 32'h0000_1234, 1, 1'b0, 32'h2000, 4'b1100, 32'h1234_0000, 32'h0, 4'h0, 32'h0};
    vecs[2] = '{32'h0000_2001, 2'd1, 32'h0000_1234, 1, 1'b0, 32'h2000, 4'b0110, 32'h0012_3400, 32'h0, 4'h0, 32'h0};
    vecs[3] = '{32'h0000_3003, 2'd2, 32'hDDCC_BBAA, 2, 1'b0, 32'h3000, 4'b1000, 32'hAA00_0000, 32'h3004, 4'b0111, 32'h00DD_CCBB};
    vecs[4] = '{32'hFFFF_FFFE, 2'd2, 32'hDDCC_BBAA, 2, 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'hBBAA_0000, 32'h0, 4'b0011, 32'h0000_DDCC};
    vecs[5] = '{32'h0000_0010, 2'd3, 32'h1234_5678, 0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[6] = '{32'h0000_1003, 2'd1, 32'h0000_5566, 2, 1'b0, 32'h1000, 4'b1000, 32'h6600_0000, 32'h1004, 4'b0001, 32'h0000_0055};
    vecs[7] = '{32'h0000_4000, 2'd2, 32'hCAFE_F00D, 1, 1'b0, 32'h4000, 4'b1111, 32'hCAFE_F00D, 32'h0, 4'h0, 32'h0};
    vecs[8] = '{32'h0000_1003, 2'd0, 32'hFFFF_FFAB, 1, 1'b0, 32'h1000, 4'b1000, 32'hAB00_0000, 32'h0, 4'h0, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_op = '0; req_wdata = '0; bus_ready = 1'b0;
    n_req_valid = 1'b0; n_req_addr = '0; n_req_op = '0; n_req_wdata = '0; n_bus_ready = 1'b1;
    w_req_valid = 1'b0; w_req_addr = '0; w_req_op = '0; w_req_wdata = '0; w_bus_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_bus_be", 64'(bus_be), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 9; v++) begin
      exp_addr[0] = vecs[v].a0; exp_be[0] = vecs[v].b0; exp_wd[0] = vecs[v].w0;
      exp_addr[1] = vecs[v].a1; exp_be[1] = vecs[v].b1; exp_wd[1] = vecs[v].w1;
      run_store(vecs[v].addr, vecs[v].op, vecs[v].data, 0);
      check_result($sformatf("vec%0d", v), vecs[v].n, vecs[v].e, 0);
    end

    // Randomized stores with bus back-pressure against the byte-walk model
    for (int r = 0; r < 150; r++) begin
      a = $urandom;
      if (r % 8 == 0) a = 32'hFFFF_FFF8 | 32'($urandom_range(7));
      op = 2'($urandom_range(3));
      d  = $urandom;
      model(a, op, d, en, eerr);
      run_store(a, op, d, 30);
      check_result("rand", en, eerr, 30);
    end

    // Stall in BEAT0, then reset while in BEAT1
    req_valid = 1'b1; req_addr = 32'h3003; req_op = 2'd2; req_wdata = 32'hDDCC_BBAA; bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int s = 0; s < 3; s++) begin
      chk("hold_valid", 64'(bus_valid), 64'd1);
      chk("hold_addr", 64'(bus_addr), 64'h3000);
      chk("hold_be", 64'(bus_be), 64'b1000);
      chk("hold_wdata", 64'(bus_wdata), 64'hAA00_0000);
      chk("hold_no_done", 64'(done), 64'd0);
      if (s < 2) begin @(posedge clk); @(negedge clk); end
    end
    bus_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_ready = 1'b0;
    chk("beat1_addr", 64'(bus_addr), 64'h3004);
    chk("beat1_be", 64'(bus_be), 64'b0111);
    rst = 1'b1;
    #1;
    chk("midrst_bus_valid", 64'(bus_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_bus_be", 64'(bus_be), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("postrst_no_done", 64'(done), 64'd0);
      chk("postrst_no_err", 64'(err), 64'd0);
      chk("postrst_no_valid", 64'(bus_valid), 64'd0);
    end

    // Reject instance: crossing store errors, fitting misaligned half is fine
    n_req_valid = 1'b1; n_req_addr = 32'h3003; n_req_op = 2'd2; n_req_wdata = 32'hDDCC_BBAA;
    @(posedge clk); @(negedge clk);
    n_req_valid = 1'b0;
    chk("nos_err_c1", 64'(n_err), 64'd1);
    chk("nos_valid_c1", 64'(n_bus_valid), 64'd0);
    chk("nos_done_c1", 64'(n_done), 64'd0);
    @(negedge clk);
    chk("nos_err_c2", 64'(n_err), 64'd0);
    chk("nos_valid_c2", 64'(n_bus_valid), 64'd0);
    chk("nos_done_c2", 64'(n_done), 64'd0);
    chk("nos_ready_c2", 64'(n_req_ready), 64'd1);
    n_req_valid = 1'b1; n_req_addr = 32'h2001; n_req_op = 2'd1; n_req_wdata = 32'h0000_1234;
    @(posedge clk); @(negedge clk);
    n_req_valid = 1'b0;
    chk("nos_half_valid", 64'(n_bus_valid), 64'd1);
    chk("nos_half_be", 64'(n_bus_be), 64'b0110);
    chk("nos_half_wdata", 64'(n_bus_wdata), 64'h0012_3400);
    @(negedge clk);
    chk("nos_half_done", 64'(n_done), 64'd1);
    chk("nos_half_err", 64'(n_err), 64'd0);
    @(negedge clk);

    // 64-bit instance
    w_req_valid = 1'b1; w_req_addr = 32'h40; w_req_op = 2'd3; w_req_wdata = 64'h1122_3344_5566_7788;
    @(posedge clk); @(negedge clk);
    w_req_valid = 1'b0;
    chk("d64_dw_valid", 64'(w_bus_valid), 64'd1);
    chk("d64_dw_addr", 64'(w_bus_addr), 64'h40);
    chk("d64_dw_be", 64'(w_bus_be), 64'hFF);
    chk("d64_dw_wdata", w_bus_wdata, 64'h1122_3344_5566_7788);
    @(negedge clk);
    chk("d64_dw_done", 64'(w_done), 64'd1);
    @(negedge clk);
    chk("d64_ready", 64'(w_req_ready), 64'd1);
    w_req_valid = 1'b1; w_req_addr = 32'h46; w_req_op = 2'd2; w_req_wdata = 64'h0000_0000_DDCC_BBAA;
    @(posedge clk); @(negedge clk);
    w_req_valid = 1'b0;
    chk("d64_w_b0_addr", 64'(w_bus_addr), 64'h40);
    chk("d64_w_b0_be", 64'(w_bus_be), 64'hC0);
    chk("d64_w_b0_wdata", w_bus_wdata, 64'hBBAA_0000_0000_0000);
    @(negedge clk);
    chk("d64_w_b1_addr", 64'(w_bus_addr), 64'h48);
    chk("d64_w_b1_be", 64'(w_bus_be), 64'h03);
    chk("d64_w_b1_wdata", w_bus_wdata, 64'h0000_0000_0000_DDCC);
    @(negedge clk);
    chk("d64_w_done", 64'(w_done), 64'd1);
    chk("d64_w_no_err", 64'(w_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_lane_ctrl.md
# store_lane_ctrl

Parametrised store path between the datapath and the data-memory bus. It generates byte enables and lane-aligned write data for byte, half, word and (when DW=64) dword stores at any byte address. Stores that cross a bus-word boundary are either split into two bus beats or rejected with an error pulse. It sits after the address/data registers in the memory stage and owns the memory write handshake.

## Interface
Parameters:
- DW, 32: bus data width in bits; legal values are 32 or 64. BEW = DW/8 lanes; OW = log2(BEW).
- AW, 32: address width.
- SPLIT_MISALIGNED, 1: 1 = split boundary-crossing stores into two beats; 0 = reject them with err.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  AW  byte address.
- req_op  in  2  00 byte, 01 half, 10 word, 11 dword (dword is legal only when DW=64).
- req_wdata  in  DW  store data, right-justified.
- bus_valid  out  1  bus write beat valid.
- bus_ready  in  1  bus accepts the beat.
- bus_addr  out  AW  bus-word-aligned address (low OW bits are 0).
- bus_wdata  out  DW  lane-aligned write data; lanes not enabled are 0.
- bus_be  out  BEW  byte enables; bit i enables lane i (little-endian).
- done  out  1  one-cycle pulse when the store is complete.
- err  out  1  one-cycle pulse when a store is rejected.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, DONE, ERR.
- IDLE: req_ready=1. When req_valid=1, the block latches addr, op and data, then computes:
  - n = 1<<op (size in bytes);
  - off = addr[OW-1:0];
  - base = {addr[AW-1:OW], OW'b0}.
- Accept-time decision:
  - op illegal for DW (op=11 with DW=32) → ERR.
  - off+n ≤ BEW → BEAT0, marked last.
  - Otherwise, if SPLIT_MISALIGNED=1 → BEAT0, marked not last.
  - Otherwise → ERR.
- BEAT0 outputs:
  - bus_addr = base;
  - bus_be = (((1<<n)-1) << off) truncated to BEW bits;
  - bus_wdata = (data << 8*off) truncated to DW bits.
- BEAT1 outputs:
  - bus_addr = base + BEW, wrapping modulo 2^AW;
  - bus_be = ((1<<n)-1) >> (BEW-off);
  - bus_wdata = data >> 8*(BEW-off).
- BEAT0/BEAT1 hold until bus_valid && bus_ready. Then the FSM goes to BEAT1 if not last, otherwise to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, bus_valid stays 0, then IDLE.
- A store that fits in one bus word but is not naturally aligned (e.g. half at off=1) is a legal single beat.
- Byte lane order is little-endian: the lowest data byte goes to the lowest address.

## Timing
- Reset values: req_ready=1 (state IDLE); bus_valid=0; bus_addr=0; bus_wdata=0; bus_be=0; done=0; err=0.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or bus_ready to any output.
- Accept at edge 0: bus_valid=1 from cycle 1.
- Single beat with bus_ready=1: the handshake completes in cycle 1 and done pulses in cycle 2. req_ready returns to 1 in cycle 3.
- Split store with bus_ready=1: beats in cycles 1 and 2, done in cycle 3.
- Rejected store: err pulses in cycle 1; req_ready=1 again in cycle 2.
- While bus_valid=1 and bus_ready=0, bus_addr, bus_wdata and bus_be stay stable.
- req_wdata and req_addr are sampled only at accept and may change afterwards.
- Asserting rst in any state forces IDLE and clears all outputs immediately. This includes rst mid-beat and between BEAT0 and BEAT1: no beat is retried, and the partial write is the bus side's concern. done is not pulsed.
- done and err are never high in the same cycle.

## Test plan
- DW=32, byte at 0x1003, data 0xAB, bus_ready=1 → one beat: addr 0x1000, be 1000, wdata 0xAB000000; done in cycle 2.
- Half at 0x2002, data 0x1234 → addr 0x2000, be 1100, wdata 0x12340000. Half at 0x2001 → be 0110, wdata 0x00123400, single beat.
- SPLIT_MISALIGNED=1, word at 0x3003, data 0xDDCCBBAA:
  - beat0: addr 0x3000, be 1000, wdata 0xAA000000;
  - beat1: addr 0x3004, be 0111, wdata 0x00DDCCBB;
  - done in cycle 3.
  - Repeat at 0xFFFFFFFE (addr = 0xFFFFFFFC, off = 2): beat0 addr 0xFFFFFFFC, be 1100; beat1 addr wraps to 0x00000000, be 0011.
- SPLIT_MISALIGNED=0, same store at 0x3003 → err pulse in cycle 1, bus_valid never asserted, no done.
- DW=32, op=11 → err. DW=64, dword at 0x40, data 0x1122334455667788 → be 0xFF, wdata unchanged. DW=64 word at 0x46 → be 0xC0 then 0x03.
- Hold bus_ready=0 for 3 cycles during BEAT0 → outputs stable, no done. Then assert rst during BEAT1 → bus_valid=0 the same cycle, req_ready=1, and no done/err pulse.
